// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width and the FSM-to-datapath control strobe bundle.
package div_pkg;
  localparam int DIV_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_Q = 4'd1,
    LOAD_M = 4'd2,
    SHIFT  = 4'd3,
    SUB    = 4'd4,
    INCR   = 4'd5,
    OUT_Q  = 4'd6,
    OUT_R  = 4'd7
  } div_state_e;

  // At most one strobe is high in any cycle.
  typedef struct packed {
    logic ld_q;
    logic ld_m;
    logic shift;
    logic sub;
    logic incr;
  } div_ctrl_t;
endpackage

// File: rtl/div_if.sv
// Shared-bus handshake between the ALU top level and the divider.
interface div_if #(parameter int WIDTH = div_pkg::DIV_WIDTH);
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] inbus;
  logic [WIDTH-1:0] outbus;
  logic             out_valid;
  logic             out_sel;
  logic             busy;
  logic             div_by_zero;

  modport master (output enable, start, inbus,
                  input  outbus, out_valid, out_sel, busy, div_by_zero);
  modport slave  (input  enable, start, inbus,
                  output outbus, out_valid, out_sel, busy, div_by_zero);
endinterface

// File: rtl/div_datapath.sv
// A/Q/M/count registers of the restoring divider with subtractor, shifter and
// divisor-zero detect; every update is triggered by one control strobe.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  div_ctrl_t        ctrl_i,
  input  logic [WIDTH-1:0] inbus_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dneg_o,
  output logic             cnt_last_o,
  output logic             dvsr_zero_o,
  output logic             dbz_o
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH:0]   a_q, a_d, diff;
  logic [WIDTH-1:0] q_q, q_d, m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  assign diff        = a_q - {1'b0, m_q};
  assign dneg_o      = diff[WIDTH];
  assign cnt_last_o  = (cnt_q == CW'(WIDTH - 1));
  assign dvsr_zero_o = (inbus_i == '0);
  assign quo_o       = q_q;
  assign rem_o       = a_q[WIDTH-1:0];
  assign dbz_o       = dbz_q;

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (ctrl_i.ld_q) begin
      q_d   = inbus_i;
      a_d   = '0;
      cnt_d = '0;
      dbz_d = 1'b0;
    end
    if (ctrl_i.ld_m) begin
      m_d = inbus_i;
      // Zero divisor skips iterations: quotient saturates, remainder = dividend.
      if (dvsr_zero_o) begin
        a_d   = {1'b0, q_q};
        q_d   = '1;
        dbz_d = 1'b1;
      end
    end
    if (ctrl_i.shift) {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
    if (ctrl_i.sub) begin
      if (!diff[WIDTH]) begin
        a_d    = diff;
        q_d[0] = 1'b1;
      end else begin
        q_d[0] = 1'b0;
      end
    end
    if (ctrl_i.incr) cnt_d = cnt_last_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end
endmodule

// File: rtl/div_unit.sv
// Sequential unsigned restoring divider: control FSM driving div_datapath,
// quotient then remainder presented on outbus one cycle each.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  div_state_e       state_q, state_d;
  div_ctrl_t        ctrl;
  logic [WIDTH-1:0] quo, rem;
  logic             dneg, cnt_last, dvsr_zero, dbz;

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .ctrl_i     (ctrl),
    .inbus_i    (bus.inbus),
    .quo_o      (quo),
    .rem_o      (rem),
    .dneg_o     (dneg),
    .cnt_last_o (cnt_last),
    .dvsr_zero_o(dvsr_zero),
    .dbz_o      (dbz)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    // Dropping enable aborts from any state; strobes stay low so registers hold.
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.start) state_d = LOAD_Q;
        LOAD_Q:  begin ctrl.ld_q = 1'b1; state_d = LOAD_M; end
        LOAD_M:  begin ctrl.ld_m = 1'b1; state_d = dvsr_zero ? OUT_Q : SHIFT; end
        SHIFT:   begin ctrl.shift = 1'b1; state_d = SUB; end
        SUB:     begin ctrl.sub = 1'b1; state_d = INCR; end
        INCR:    begin ctrl.incr = 1'b1; state_d = cnt_last ? OUT_Q : SHIFT; end
        OUT_Q:   state_d = OUT_R;
        OUT_R:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = (state_q == OUT_Q) || (state_q == OUT_R);
  assign bus.out_sel     = (state_q == OUT_R);
  assign bus.outbus      = (state_q == OUT_Q) ? quo :
                           (state_q == OUT_R) ? rem : '0;
  assign bus.div_by_zero = dbz;

  // dneg is consumed inside the datapath; exported only for observability.
  logic unused_ok;
  assign unused_ok = dneg;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus random operands
// checked against plain integer division.
module tb_div_unit;
  localparam int W   = 8;
  localparam int LAT = 3 + 3 * W;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) dif ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(dif));

  // Runs one operation starting at the next negedge (the IDLE start cycle t).
  // lat is the cycle offset from t at which out_valid first appears.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit hold_start,
                        output logic [W-1:0] q, output logic [W-1:0] r, output int lat,
                        output logic selq, output logic selr, output logic dbz, output int vseen);
    vseen = 0;
    @(negedge clk); dif.enable = 1'b1; dif.start = 1'b1;
    @(negedge clk); dif.start = hold_start; dif.inbus = dd; vseen += int'(dif.out_valid);
    @(negedge clk); dif.inbus = dv; vseen += int'(dif.out_valid);
    lat = 2;
    while (lat < 200) begin
      @(negedge clk); lat++;
      dif.inbus = W'($urandom);
      if (dif.out_valid) break;
    end
    q = dif.outbus; selq = dif.out_sel; dbz = dif.div_by_zero; vseen += int'(dif.out_valid);
    @(negedge clk);
    r = dif.outbus; selr = dif.out_sel; vseen += int'(dif.out_valid);
  endtask

  task automatic test_reset;
    rst = 1'b1; dif.enable = 1'b0; dif.start = 1'b0; dif.inbus = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", dif.busy); end
    n_chk++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dif.out_valid); end
    n_chk++; if (dif.outbus !== '0) begin n_fail++; $display("FAIL reset_outbus got %h exp 00", dif.outbus); end
    n_chk++; if (dif.out_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b exp 0", dif.out_sel); end
    n_chk++; if (dif.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b exp 0", dif.div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] dd[4] = '{8'd100, 8'hFF, 8'd5, 8'd0};
    logic [W-1:0] dv[4] = '{8'd7, 8'h01, 8'd9, 8'd3};
    logic [W-1:0] eq[4] = '{8'd14, 8'hFF, 8'd0, 8'd0};
    logic [W-1:0] er[4] = '{8'd2, 8'd0, 8'd5, 8'd0};
    logic [W-1:0] q, r; logic sq, sr, dbz; int lat, vs;
    for (int i = 0; i < 4; i++) begin
      run_op(dd[i], dv[i], 1'b0, q, r, lat, sq, sr, dbz, vs);
      n_chk++; if (q !== eq[i]) begin n_fail++; $display("FAIL dir_q[%0d] got %0d exp %0d", i, q, eq[i]); end
      n_chk++; if (r !== er[i]) begin n_fail++; $display("FAIL dir_r[%0d] got %0d exp %0d", i, r, er[i]); end
      n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL dir_lat[%0d] got %0d exp %0d", i, lat, LAT); end
      n_chk++; if ({sq, sr} !== 2'b01) begin n_fail++; $display("FAIL dir_sel[%0d] got %b exp 01", i, {sq, sr}); end
      n_chk++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL dir_dbz[%0d] got %b exp 0", i, dbz); end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] q, r; logic sq, sr, dbz; int lat, vs;
    run_op(8'd37, 8'd0, 1'b0, q, r, lat, sq, sr, dbz, vs);
    n_chk++; if (q !== 8'hFF) begin n_fail++; $display("FAIL dz_q got %h exp ff", q); end
    n_chk++; if (r !== 8'd37) begin n_fail++; $display("FAIL dz_r got %0d exp 37", r); end
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL dz_lat got %0d exp 3", lat); end
    n_chk++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b exp 1", dbz); end
    @(negedge clk);
    n_chk++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL dz_idle got %b exp 0", dif.busy); end
    run_op(8'd50, 8'd5, 1'b0, q, r, lat, sq, sr, dbz, vs);
    n_chk++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL dz_clear got %b exp 0", dbz); end
    n_chk++; if (q !== 8'd10 || r !== 8'd0) begin n_fail++; $display("FAIL dz_next got %0d/%0d exp 10/0", q, r); end
  endtask

  task automatic test_abort;
    logic [W-1:0] q, r; logic sq, sr, dbz; int lat, vs, vcount;
    @(negedge clk); dif.enable = 1'b1; dif.start = 1'b1;
    @(negedge clk); dif.start = 1'b0; dif.inbus = 8'd99;
    @(negedge clk); dif.inbus = 8'd4;
    repeat (8) @(negedge clk);   // now in cycle t+10: SUB of the third iteration
    n_chk++; if (dif.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b exp 1", dif.busy); end
    dif.enable = 1'b0;
    @(negedge clk);
    n_chk++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b exp 0", dif.busy); end
    vcount = 0;
    repeat (4) begin @(negedge clk); vcount += int'(dif.out_valid); end
    dif.enable = 1'b1;
    repeat (30) begin @(negedge clk); vcount += int'(dif.out_valid) + int'(dif.busy); end
    n_chk++; if (vcount != 0) begin n_fail++; $display("FAIL abort_quiet got %0d exp 0", vcount); end
    dif.enable = 1'b0;
    run_op(8'd200, 8'd13, 1'b0, q, r, lat, sq, sr, dbz, vs);
    n_chk++; if (q !== 8'd15 || r !== 8'd5) begin n_fail++; $display("FAIL abort_fresh got %0d/%0d exp 15/5", q, r); end
    n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL abort_lat got %0d exp %0d", lat, LAT); end
  endtask

  task automatic test_rst_mid;
    logic [W-1:0] q, r; logic sq, sr, dbz; int lat, vs;
    @(negedge clk); dif.enable = 1'b1; dif.start = 1'b1;
    @(negedge clk); dif.start = 1'b0; dif.inbus = 8'd123;
    @(negedge clk); dif.inbus = 8'd10;
    repeat (6) @(negedge clk);
    rst = 1'b1; #1;
    n_chk++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL rst_iter_busy got %b exp 0", dif.busy); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); dif.start = 1'b1;
    @(negedge clk); dif.start = 1'b0; dif.inbus = 8'd37;
    @(negedge clk); dif.inbus = 8'd0;
    @(negedge clk);              // OUT_Q of a divide-by-zero op
    n_chk++; if (dif.out_valid !== 1'b1 || dif.div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got v=%b dz=%b exp 1/1", dif.out_valid, dif.div_by_zero); end
    rst = 1'b1; #1;
    n_chk++; if ({dif.out_valid, dif.out_sel, dif.busy, dif.div_by_zero} !== 4'b0000 || dif.outbus !== '0) begin
      n_fail++; $display("FAIL rst_outq got v%b s%b b%b dz%b o%h exp all 0",
                         dif.out_valid, dif.out_sel, dif.busy, dif.div_by_zero, dif.outbus); end
    @(negedge clk); rst = 1'b0;
    run_op(8'd60, 8'd7, 1'b0, q, r, lat, sq, sr, dbz, vs);
    n_chk++; if (q !== 8'd8 || r !== 8'd4) begin n_fail++; $display("FAIL rst_after got %0d/%0d exp 8/4", q, r); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q, r; logic sq, sr, dbz; int lat, vs;
    run_op(8'd100, 8'd7, 1'b1, q, r, lat, sq, sr, dbz, vs);
    n_chk++; if (q !== 8'd14 || r !== 8'd2 || lat != LAT) begin
      n_fail++; $display("FAIL b2b_first got %0d/%0d lat %0d exp 14/2 lat %0d", q, r, lat, LAT); end
    run_op(8'd201, 8'd10, 1'b0, q, r, lat, sq, sr, dbz, vs);
    n_chk++; if (q !== 8'd20 || r !== 8'd1 || lat != LAT) begin
      n_fail++; $display("FAIL b2b_second got %0d/%0d lat %0d exp 20/1 lat %0d", q, r, lat, LAT); end
  endtask

  task automatic test_random;
    logic [W-1:0] dd, dv, q, r, eq, er; logic sq, sr, dbz; int lat, vs;
    for (int i = 0; i < 1500; i++) begin
      dd = W'($urandom);
      dv = W'($urandom_range(1, 255));
      eq = dd / dv; er = dd % dv;
      run_op(dd, dv, 1'b0, q, r, lat, sq, sr, dbz, vs);
      n_chk++; if (q !== eq) begin n_fail++; $display("FAIL rnd_q %0d/%0d got %0d exp %0d", dd, dv, q, eq); end
      n_chk++; if (r !== er) begin n_fail++; $display("FAIL rnd_r %0d/%0d got %0d exp %0d", dd, dv, r, er); end
      n_chk++; if (vs != 2) begin n_fail++; $display("FAIL rnd_valid %0d/%0d got %0d exp 2", dd, dv, vs); end
      n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL rnd_lat %0d/%0d got %0d exp %0d", dd, dv, lat, LAT); end
    end
    @(negedge clk);
    n_chk++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_tail got %b exp 0", dif.out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
